// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: bundles the fetch sequencer's control, memory and instruction-buffer signals.
//
// Signals:
//   redirect_valid/redirect_target    branch/exception redirect (target bits [1:0] ignored)
//   ibuf_count                        instruction buffer occupancy
//   mem_stall                         backend stall, blocks new requests
//   fetch_req_valid/ready/addr        request channel to the instruction memory arbiter
//   fetch_resp_valid/data             single-cycle response from the arbiter
//   aligned_instr/_valid/aligned_pc   instruction pair to the instruction buffer
//   clear_ibuffer                     one-cycle flush pulse to the instruction buffer
//   perf_req_cnt/perf_drop_cnt        optional performance counters
//
// Modports:
//   master  fetch sequencer side (drives requests and aligned output)
//   slave   environment side (arbiter, instruction buffer, backend)

interface fetch_ctrl_if #(
  parameter int unsigned CNT_W = 6
);
  logic             redirect_valid;
  logic [63:0]      redirect_target;
  logic [CNT_W-1:0] ibuf_count;
  logic             mem_stall;
  logic             fetch_req_valid;
  logic             fetch_req_ready;
  logic [63:0]      fetch_req_addr;
  logic             fetch_resp_valid;
  logic [63:0]      fetch_resp_data;
  logic [63:0]      aligned_instr;
  logic [1:0]       aligned_instr_valid;
  logic [63:0]      aligned_pc;
  logic             clear_ibuffer;
  logic [31:0]      perf_req_cnt;
  logic [31:0]      perf_drop_cnt;

  modport master (
    input  redirect_valid,
    input  redirect_target,
    input  ibuf_count,
    input  mem_stall,
    output fetch_req_valid,
    input  fetch_req_ready,
    output fetch_req_addr,
    input  fetch_resp_valid,
    input  fetch_resp_data,
    output aligned_instr,
    output aligned_instr_valid,
    output aligned_pc,
    output clear_ibuffer,
    output perf_req_cnt,
    output perf_drop_cnt
  );

  modport slave (
    output redirect_valid,
    output redirect_target,
    output ibuf_count,
    output mem_stall,
    input  fetch_req_valid,
    output fetch_req_ready,
    input  fetch_req_addr,
    output fetch_resp_valid,
    output fetch_resp_data,
    input  aligned_instr,
    input  aligned_instr_valid,
    input  aligned_pc,
    input  clear_ibuffer,
    input  perf_req_cnt,
    input  perf_drop_cnt
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: front-end fetch sequencer.
//
// Owns the fetch PC and issues 8-byte-aligned requests to the instruction memory arbiter, one
// outstanding at a time. Each response is turned into an aligned instruction pair (two
// instructions, or only the upper one when the PC points into the upper word). Requests are
// throttled on instruction buffer free space and on mem_stall. A redirect reloads the PC,
// flushes the instruction buffer and discards any response still in flight.
//
// Ports:
//   clock   system clock
//   reset   asynchronous active-high reset
//   bus     fetch_ctrl_if.master (redirect, ibuf status, request/response, aligned output,
//           flush pulse, perf counters)
//
// Parameters:
//   RESET_PC    fetch PC after reset
//   IBUF_DEPTH  instruction buffer capacity in entries
//   CNT_W       width of ibuf_count
//
// Build option:
//   FETCH_PERF_CNT_EN  when defined, perf_req_cnt / perf_drop_cnt count request handshakes
//                      and discarded responses; otherwise both ports are tied to zero.

module fetch_ctrl #(
  parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
  parameter int unsigned IBUF_DEPTH = 24,
  parameter int unsigned CNT_W      = 6
) (
  input logic          clock,
  input logic          reset,
  fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    StIdle,  // nothing outstanding
    StReq,   // request presented to the arbiter
    StWait,  // request accepted, response pending
    StDrop   // response pending but stale after a redirect
  } state_e;

  state_e state_q, state_d;

  logic [63:0] pc_q, pc_d;
  logic [63:0] req_pc_q, req_pc_d;
  logic [63:0] instr_q, instr_d;
  logic [63:0] apc_q, apc_d;
  logic [1:0]  avalid_q, avalid_d;
  logic        clear_q, clear_d;

  logic [CNT_W-1:0] ibuf_count;
  logic             free_ok;
  logic             can_issue;
  logic             req_fire;
  logic             resp_drop;
  logic             unused_tgt_lsb;

  assign ibuf_count = bus.ibuf_count;

  // Four free slots: one response in flight plus one write still settling inside the buffer.
  // Widened by one bit so an occupancy above IBUF_DEPTH never wraps into "free".
  assign free_ok = ({1'b0, 32'(ibuf_count)} + 33'd4) <= {1'b0, 32'(IBUF_DEPTH)};

  assign can_issue = free_ok && !bus.mem_stall && !bus.redirect_valid;
  assign req_fire  = (state_q == StReq) && bus.fetch_req_ready;

  // Low target bits are architecturally ignored.
  assign unused_tgt_lsb = ^bus.redirect_target[1:0];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    instr_d   = '0;
    apc_d     = '0;
    avalid_d  = 2'b00;
    clear_d   = 1'b0;
    resp_drop = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (can_issue) begin
          state_d = StReq;
        end
      end

      StReq: begin
        if (req_fire) begin
          req_pc_d = pc_q;
          state_d  = bus.redirect_valid ? StDrop : StWait;
        end else if (bus.redirect_valid) begin
          state_d = StIdle;
        end
      end

      StWait: begin
        if (bus.fetch_resp_valid) begin
          state_d = StIdle;
          if (bus.redirect_valid) begin
            resp_drop = 1'b1;
          end else if (!req_pc_q[2]) begin
            instr_d  = bus.fetch_resp_data;
            avalid_d = 2'b11;
            apc_d    = req_pc_q;
            pc_d     = req_pc_q + 64'd8;
          end else begin
            // PC points at the upper word: only that instruction is valid.
            instr_d  = {32'b0, bus.fetch_resp_data[63:32]};
            avalid_d = 2'b01;
            apc_d    = req_pc_q;
            pc_d     = {req_pc_q[63:3], 3'b000} + 64'd8;
          end
        end else if (bus.redirect_valid) begin
          state_d = StDrop;
        end
      end

      StDrop: begin
        if (bus.fetch_resp_valid) begin
          resp_drop = 1'b1;
          state_d   = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    // Redirect overrides everything above, including a same-cycle PC advance.
    if (bus.redirect_valid) begin
      pc_d     = {bus.redirect_target[63:2], 2'b00};
      clear_d  = 1'b1;
      avalid_d = 2'b00;
      instr_d  = '0;
      apc_d    = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      instr_q  <= '0;
      apc_q    <= '0;
      avalid_q <= 2'b00;
      clear_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      instr_q  <= instr_d;
      apc_q    <= apc_d;
      avalid_q <= avalid_d;
      clear_q  <= clear_d;
    end
  end

  assign bus.fetch_req_valid     = (state_q == StReq);
  assign bus.fetch_req_addr      = {pc_q[63:3], 3'b000};
  assign bus.aligned_instr       = instr_q;
  assign bus.aligned_instr_valid = avalid_q;
  assign bus.aligned_pc          = apc_q;
  assign bus.clear_ibuffer       = clear_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] req_cnt_q;
  logic [31:0] drop_cnt_q;

  // Cleared only by reset; redirects leave them running.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (req_fire) begin
        req_cnt_q <= req_cnt_q + 32'd1;
      end
      if (resp_drop) begin
        drop_cnt_q <= drop_cnt_q + 32'd1;
      end
    end
  end

  assign bus.perf_req_cnt  = req_cnt_q;
  assign bus.perf_drop_cnt = drop_cnt_q;
`else
  logic unused_perf;
  assign unused_perf       = resp_drop;
  assign bus.perf_req_cnt  = '0;
  assign bus.perf_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  localparam logic [63:0] ResetPc = 64'h0000_0000_8000_0000;

  logic clock;
  logic reset;

  fetch_ctrl_if #(.CNT_W(6)) bus ();

  fetch_ctrl #(
    .RESET_PC  (ResetPc),
    .IBUF_DEPTH(24),
    .CNT_W     (6)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] instr;
    logic [1:0]  valid;
    logic [63:0] pc;
  } exp_t;

  typedef struct {
    bit          redir;
    logic [63:0] target;
    logic [63:0] addr;
    logic [63:0] data;
    logic [1:0]  valid;
    logic [63:0] instr;
    logic [63:0] pc;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[7];

  int errors = 0;
  int checks = 0;
  int exp_req = 0;
  int exp_drop = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_req(input string name, input logic [63:0] addr, input int limit);
    int n = 0;
    while (bus.fetch_req_valid !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    check64({name, "_req_valid"}, 64'(bus.fetch_req_valid), 64'd1);
    check64({name, "_req_addr"}, bus.fetch_req_addr, addr);
  endtask

  task automatic accept();
    bus.fetch_req_ready = 1'b1;
    tick();
    bus.fetch_req_ready = 1'b0;
    exp_req++;
  endtask

  task automatic respond(input logic [63:0] data, input bit push, input exp_t e);
    bus.fetch_resp_valid = 1'b1;
    bus.fetch_resp_data  = data;
    if (push) sb_q.push_back(e);
    tick();
    bus.fetch_resp_valid = 1'b0;
    bus.fetch_resp_data  = '0;
  endtask

  task automatic check_perf(input string name);
`ifdef FETCH_PERF_CNT_EN
    check64({name, "_perf_req"}, 64'(bus.perf_req_cnt), 64'(exp_req));
    check64({name, "_perf_drop"}, 64'(bus.perf_drop_cnt), 64'(exp_drop));
`else
    check64({name, "_perf_req"}, 64'(bus.perf_req_cnt), 64'd0);
    check64({name, "_perf_drop"}, 64'(bus.perf_drop_cnt), 64'd0);
`endif
  endtask

  // Scoreboard: every aligned output must match the oldest pending expectation.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (!reset && bus.aligned_instr_valid !== 2'b00) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got valid=%b pc=%h expected no output",
                 bus.aligned_instr_valid, bus.aligned_pc);
      end else begin
        e = sb_q.pop_front();
        check64("aligned_valid", 64'(bus.aligned_instr_valid), 64'(e.valid));
        check64("aligned_instr", bus.aligned_instr, e.instr);
        check64("aligned_pc", bus.aligned_pc, e.pc);
      end
    end
  end

  initial begin
    int hi;

    vecs[0] = '{0, 64'h0, 64'h8000_0000, 64'h2222_2222_1111_1111, 2'b11,
                64'h2222_2222_1111_1111, 64'h8000_0000};
    vecs[1] = '{0, 64'h0, 64'h8000_0008, 64'h4444_4444_3333_3333, 2'b11,
                64'h4444_4444_3333_3333, 64'h8000_0008};
    vecs[2] = '{1, 64'h8000_0104, 64'h8000_0100, 64'hBBBB_BBBB_AAAA_AAAA, 2'b01,
                64'h0000_0000_BBBB_BBBB, 64'h8000_0104};
    vecs[3] = '{0, 64'h0, 64'h8000_0108, 64'h6666_6666_5555_5555, 2'b11,
                64'h6666_6666_5555_5555, 64'h8000_0108};
    vecs[4] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1234_5678_9ABC_DEF0,
                2'b01, 64'h0000_0000_1234_5678, 64'hFFFF_FFFF_FFFF_FFFC};
    vecs[5] = '{0, 64'h0, 64'h0, 64'hCAFE_F00D_DEAD_BEEF, 2'b11,
                64'hCAFE_F00D_DEAD_BEEF, 64'h0};
    vecs[6] = '{1, 64'h1000_0003, 64'h1000_0000, 64'h7777_7777_8888_8888, 2'b11,
                64'h7777_7777_8888_8888, 64'h1000_0000};

    reset                = 1'b1;
    bus.redirect_valid   = 1'b0;
    bus.redirect_target  = '0;
    bus.ibuf_count       = '0;
    bus.mem_stall        = 1'b0;
    bus.fetch_req_ready  = 1'b0;
    bus.fetch_resp_valid = 1'b0;
    bus.fetch_resp_data  = '0;

    tick();
    tick();
    check64("rst_req_valid", 64'(bus.fetch_req_valid), 64'd0);
    check64("rst_req_addr", bus.fetch_req_addr, ResetPc);
    check64("rst_aligned_valid", 64'(bus.aligned_instr_valid), 64'd0);
    check64("rst_clear", 64'(bus.clear_ibuffer), 64'd0);
    check64("rst_aligned_pc", bus.aligned_pc, 64'd0);
    check_perf("rst");
    reset = 1'b0;

    // Table-driven fetches, some preceded by a redirect from IDLE.
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].redir) begin
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = vecs[i].target;
        tick();
        bus.redirect_valid = 1'b0;
        check64($sformatf("v%0d_clear", i), 64'(bus.clear_ibuffer), 64'd1);
        tick();
        check64($sformatf("v%0d_clear_end", i), 64'(bus.clear_ibuffer), 64'd0);
      end
      wait_req($sformatf("v%0d", i), vecs[i].addr, 10);
      accept();
      check64($sformatf("v%0d_wait_novalid", i), 64'(bus.fetch_req_valid), 64'd0);
      respond(vecs[i].data, 1, '{vecs[i].instr, vecs[i].valid, vecs[i].pc});
    end

    // Redirect while WAIT; the response arrives three cycles later and is dropped.
    wait_req("a", 64'h1000_0008, 10);
    accept();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 64'h9000_0000;
    tick();
    bus.redirect_valid = 1'b0;
    check64("a_clear", 64'(bus.clear_ibuffer), 64'd1);
    tick();
    check64("a_clear_end", 64'(bus.clear_ibuffer), 64'd0);
    tick();
    check64("a_drop_noreq", 64'(bus.fetch_req_valid), 64'd0);
    respond(64'h5555_AAAA_5555_AAAA, 0, '{64'h0, 2'b00, 64'h0});
    exp_drop++;
    check64("a_dropped", 64'(bus.aligned_instr_valid), 64'd0);
    wait_req("a_next", 64'h9000_0000, 10);
    check_perf("a");
    accept();
    respond(64'h0A0A_0A0A_0B0B_0B0B, 1, '{64'h0A0A_0A0A_0B0B_0B0B, 2'b11, 64'h9000_0000});

    // Redirect in the same cycle as the response.
    wait_req("b", 64'h9000_0008, 10);
    accept();
    bus.redirect_valid   = 1'b1;
    bus.redirect_target  = 64'hA000_0010;
    bus.fetch_resp_valid = 1'b1;
    bus.fetch_resp_data  = 64'hDEAD_DEAD_DEAD_DEAD;
    tick();
    bus.redirect_valid   = 1'b0;
    bus.fetch_resp_valid = 1'b0;
    exp_drop++;
    check64("b_clear", 64'(bus.clear_ibuffer), 64'd1);
    check64("b_dropped", 64'(bus.aligned_instr_valid), 64'd0);
    tick();
    check64("b_clear_end", 64'(bus.clear_ibuffer), 64'd0);
    wait_req("b_next", 64'hA000_0010, 10);
    check_perf("b");
    accept();
    respond(64'h1111_2222_3333_4444, 1, '{64'h1111_2222_3333_4444, 2'b11, 64'hA000_0010});

    // Free-space throttle: 3 free holds off, 4 free issues.
    bus.ibuf_count = 6'd21;
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.fetch_req_valid) hi = 1;
    end
    check64("throttle21_noreq", 64'(hi), 64'd0);
    bus.ibuf_count = 6'd20;
    wait_req("throttle20", 64'hA000_0018, 2);
    accept();
    respond(64'h9999_8888_7777_6666, 1, '{64'h9999_8888_7777_6666, 2'b11, 64'hA000_0018});

    // mem_stall holds off issue.
    bus.mem_stall = 1'b1;
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.fetch_req_valid) hi = 1;
    end
    check64("stall_noreq", 64'(hi), 64'd0);
    bus.mem_stall = 1'b0;
    wait_req("stall_release", 64'hA000_0020, 2);

    // Stray response while in REQ is ignored.
    bus.fetch_resp_valid = 1'b1;
    bus.fetch_resp_data  = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    bus.fetch_resp_valid = 1'b0;
    check64("stray_req_valid", 64'(bus.fetch_req_valid), 64'd1);
    check64("stray_req_addr", bus.fetch_req_addr, 64'hA000_0020);

    // Redirect in REQ without handshake withdraws the request.
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 64'hB000_0000;
    tick();
    bus.redirect_valid = 1'b0;
    check64("withdraw_req_valid", 64'(bus.fetch_req_valid), 64'd0);
    check64("withdraw_clear", 64'(bus.clear_ibuffer), 64'd1);
    wait_req("withdraw_next", 64'hB000_0000, 10);

    // Redirect in REQ with handshake: the accepted request's response is dropped.
    bus.fetch_req_ready = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 64'hC000_0000;
    tick();
    bus.fetch_req_ready = 1'b0;
    bus.redirect_valid  = 1'b0;
    exp_req++;
    check64("hs_redir_noreq", 64'(bus.fetch_req_valid), 64'd0);
    tick();
    check64("hs_redir_drop_noreq", 64'(bus.fetch_req_valid), 64'd0);
    respond(64'h3333_3333_3333_3333, 0, '{64'h0, 2'b00, 64'h0});
    exp_drop++;

    // Back-to-back redirects: a pulse per redirect, last target wins.
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 64'hD000_0000;
    tick();
    check64("b2b_clear1", 64'(bus.clear_ibuffer), 64'd1);
    bus.redirect_target = 64'hE000_0004;
    tick();
    bus.redirect_valid = 1'b0;
    check64("b2b_clear2", 64'(bus.clear_ibuffer), 64'd1);
    tick();
    check64("b2b_clear_end", 64'(bus.clear_ibuffer), 64'd0);
    wait_req("b2b", 64'hE000_0000, 10);
    check_perf("b2b");

    // Asynchronous reset while WAIT.
    accept();
    #2;
    reset = 1'b1;
    #1;
    check64("wrst_req_valid", 64'(bus.fetch_req_valid), 64'd0);
    check64("wrst_req_addr", bus.fetch_req_addr, ResetPc);
    check64("wrst_aligned_valid", 64'(bus.aligned_instr_valid), 64'd0);
    check64("wrst_aligned_instr", bus.aligned_instr, 64'd0);
    check64("wrst_clear", 64'(bus.clear_ibuffer), 64'd0);
    exp_req  = 0;
    exp_drop = 0;
    check_perf("wrst");
    tick();
    reset = 1'b0;
    wait_req("post_reset", ResetPc, 5);

    tick();
    check64("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
